// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: hazard/sequencing control for a 5-stage pipeline without forwarding (stall, flush, ecall halt).
// Latency: stall/flush decisions are combinational, with zero latency. is_halted rises 4 cycles after halt accept.
// Backpressure: a stall holds the PC and IF/ID and bubbles ID/EX. A drain or halt freezes the front end permanently.
//
// Ports:
//   clk, reset              core clock; asynchronous active-high reset
//   id_rs1/2, id_use_rs1/2  ID source registers and their use flags
//   id_is_ecall             ID holds ecall, which implicitly reads x17
//   id_x17_is_ten           x17 read value equals 10 (only meaningful without an x17 hazard)
//   ex/mem/wb_rd, *_reg_write  destination register and write enable per downstream stage
//   ex_redirect             EX resolved a taken branch/jump this cycle
//   pc_write, if_id_write   front-end update enables
//   if_id_flush             load a NOP into IF/ID
//   id_ex_bubble            load zeroed control into ID/EX
//   is_halted               registered, sticky until reset
//   stall_cycles, flush_count  perf counters, built only when HAZARD_PERF_EN is defined, else 0
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_is_ecall,
  input  logic        id_x17_is_ten,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ex_reg_write,
  input  logic        mem_reg_write,
  input  logic        wb_reg_write,
  input  logic        ex_redirect,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        is_halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic       is_halted_q, is_halted_d;

  logic hz_ex, hz_mem, hz_wb, raw, halt_req;

  // The register file has no write-through, so a WB-stage writer is still a hazard.
  // An ecall reads x17 implicitly, whatever its use flags say.
  assign hz_ex  = ex_reg_write && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)) ||
                   (id_is_ecall && (ex_rd == 5'd17)));
  assign hz_mem = mem_reg_write && (mem_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == mem_rd)) ||
                   (id_use_rs2 && (id_rs2 == mem_rd)) ||
                   (id_is_ecall && (mem_rd == 5'd17)));
  assign hz_wb  = wb_reg_write && (wb_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == wb_rd)) ||
                   (id_use_rs2 && (id_rs2 == wb_rd)) ||
                   (id_is_ecall && (wb_rd == 5'd17)));
  assign raw      = hz_ex || hz_mem || hz_wb;
  assign halt_req = id_is_ecall && id_x17_is_ten;

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    is_halted_d  = is_halted_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          // The instruction in ID is wrong-path, so any hazard it has does not matter.
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
        end else if (raw) begin
          // Defaults already hold the front end and bubble ID/EX.
        end else if (halt_req) begin
          // The ecall is swallowed. Three drain cycles let the instruction in EX retire.
          state_d = DRAIN;
          dcnt_d  = 2'd3;
        end else begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_bubble = 1'b0;
        end
      end
      DRAIN: begin
        // A redirect here is ignored: every older instruction has already been resolved.
        dcnt_d = dcnt_q - 2'd1;
        if (dcnt_q == 2'd1) begin
          state_d     = HALTED;
          is_halted_d = 1'b1;
        end
      end
      HALTED: begin
        is_halted_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        dcnt_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      dcnt_q      <= 2'd0;
      is_halted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      is_halted_q <= is_halted_d;
    end
  end

  assign is_halted = is_halted_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        stall_take, flush_take;

  // These events are counted only in RUN, so both counters freeze once draining starts.
  assign stall_take = (state_q == RUN) && !ex_redirect && raw;
  assign flush_take = (state_q == RUN) && ex_redirect;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_take) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_take) flush_count_d  = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB, no forwarding network). Each cycle it decides whether the PC and IF/ID register advance, whether a bubble is injected into ID/EX, and whether IF/ID is flushed on a taken branch/jump. It also owns the ecall-halt sequence: it drains the in-flight instructions and then asserts a sticky `is_halted`. It sits beside the datapath and drives the enables of the PC and pipeline registers.

## Interface
- No parameters.
- `clk` in 1: core clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `id_rs1`, `id_rs2` in 5 each: source register fields of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: ID instruction actually reads that source.
- `id_is_ecall` in 1: ID holds ecall; implicitly reads x17.
- `id_x17_is_ten` in 1: register-file read of x17 equals 10. Valid only when no x17 hazard exists.
- `ex_rd`, `mem_rd`, `wb_rd` in 5 each: destination fields in ID/EX, EX/MEM and MEM/WB.
- `ex_reg_write`, `mem_reg_write`, `wb_reg_write` in 1 each: write enables for those stages.
- `ex_redirect` in 1: EX resolved a taken branch, jal or jalr; the PC mux takes the EX target this cycle.
- `pc_write` out 1: PC register update enable.
- `if_id_write` out 1: IF/ID register update enable.
- `if_id_flush` out 1: load a NOP (0x00000013) into IF/ID.
- `id_ex_bubble` out 1: load zeroed control (no write or memory access) into ID/EX.
- `is_halted` out 1: registered, sticky halt indication.
- `stall_cycles` out 32: perf counter (see Configuration).
- `flush_count` out 32: perf counter (see Configuration).

## Operation
- Hazard condition `raw`:
  - For each stage S in {EX, MEM, WB}: `S_reg_write && S_rd != 0 && ((id_use_rs1 && id_rs1 == S_rd) || (id_use_rs2 && id_rs2 == S_rd))`.
  - The ecall x17 check adds the equivalent term with register 17 when `id_is_ecall`.
  - WB is included because the register file has no write-through.
- States: RUN, DRAIN, HALTED, plus a 2-bit drain counter `dcnt`.
- Priority in RUN, highest first:
  1. **Flush** (`ex_redirect`): `pc_write=1`, `if_id_flush=1`, `id_ex_bubble=1`, `if_id_write=1`. A hazard in ID is ignored because that instruction is wrong-path.
  2. **Stall** (`raw`): `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`, `if_id_flush=0`.
  3. **Halt accept** (`id_is_ecall && id_x17_is_ten`, no raw, no redirect): the ecall is not issued (`id_ex_bubble=1`), `pc_write=0`, `if_id_write=0`. Next state is DRAIN with `dcnt=3`.
  4. **Normal**: `pc_write=1`, `if_id_write=1`, `id_ex_bubble=0`, `if_id_flush=0`.
- An ecall with x17≠10 proceeds as a normal instruction (NOP semantics).
- **DRAIN**: `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`. `ex_redirect` is ignored: older instructions have already been resolved. `dcnt` decrements each cycle. When `dcnt==1`, the next state is HALTED.
- **HALTED**: all enables 0 and `id_ex_bubble=1`. `is_halted=1` until reset.
- All outputs are combinational from state and inputs, except `is_halted` and the counters, which are registered.

## Timing
- Reset values:
  - state RUN, `dcnt=0`, `is_halted=0`, counters 0.
  - Combinational outputs in RUN with idle inputs: `pc_write=1`, `if_id_write=1`, others 0.
- Stall/flush decisions apply in the same cycle (zero latency).
- Halt latency:
  - Halt is accepted in cycle T.
  - DRAIN lasts T+1..T+3.
  - `is_halted` rises at the start of T+4. This guarantees that the instruction in EX at T has written back at the end of T+2.
- Reset asserted mid-DRAIN or in HALTED returns the block to RUN immediately (asynchronous).
- A load followed by a dependent instruction stalls 3 cycles; a dependent ALU op also stalls 3 cycles.

## Configuration
- Macro `HAZARD_PERF_EN`.
- **Defined**:
  - `stall_cycles` increments in every RUN cycle where the stall branch is taken.
  - `flush_count` increments in every RUN cycle with `ex_redirect`.
  - Both wrap modulo 2^32 and freeze in DRAIN and HALTED.
- **Undefined**: both outputs are tied to 0 and no counter flops are built.

## Test plan
- **ALU RAW stall**: `ex_rd=5`, `ex_reg_write=1`, `id_rs1=5`, `id_use_rs1=1` → `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`. Dependence on x0 (rd=0) → no stall.
- **Stall sequence**: dependence moves EX→MEM→WB over 3 cycles → 3 stall cycles, then normal. With `HAZARD_PERF_EN`, `stall_cycles=3`.
- **Flush priority**: `ex_redirect=1` together with a RAW hazard → `if_id_flush=1`, `id_ex_bubble=1`, `pc_write=1`. `flush_count` increments by 1.
- **Halt**: ecall with `id_x17_is_ten=1` accepted at T → enables 0 during T+1..T+3, `is_halted=1` from T+4 and held for 20 more cycles. Ecall with `id_x17_is_ten=0` → normal advance, no halt.
- **x17 hazard**: ecall in ID with `mem_rd=17`, `mem_reg_write=1` → stall, not halt. The halt is accepted after the x17 write retires.
- **Async reset**: assert `reset` in the middle of the T+2 drain cycle, between clock edges → `is_halted=0` and `pc_write=1` without waiting for `clk`.
